// File: rtl/debounce_pkg.sv
// Shared types and defaults for the switch debouncer.
package debounce_pkg;

  typedef enum logic [1:0] {
    ZERO  = 2'd0,
    WAIT1 = 2'd1,
    ONE   = 2'd2,
    WAIT0 = 2'd3
  } debounce_state_t;

  localparam int DB_STABLE_CYC_DEF  = 1_000_000;
  localparam int DB_SYNC_STAGES_DEF = 2;

  // Debounced level is high in the stable-one state and while qualifying a release.
  function automatic logic is_high_state(debounce_state_t st);
    return (st == ONE) || (st == WAIT0);
  endfunction

endpackage

// File: rtl/debounce_fsm_if.sv
// Raw switch in, clean level and change tick out.
interface debounce_fsm_if;

  logic sw_raw;
  logic db_level;
  logic db_tick;

  modport master (output sw_raw, input db_level, input db_tick);
  modport slave  (input sw_raw, output db_level, output db_tick);

endinterface

// File: rtl/debounce_fsm_bit_sync.sv
// Single-bit multi-flop synchroniser for asynchronous pins.
module bit_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[STAGES-2:0], d};
    end
  end

  assign q = sync_reg[STAGES-1];

endmodule

// File: rtl/debounce_fsm.sv
// Synchronises a bouncing switch and accepts a new level only after it holds for STABLE_CYC cycles.
module debounce_fsm
  import debounce_pkg::*;
#(
  parameter int STABLE_CYC  = DB_STABLE_CYC_DEF,
  parameter int SYNC_STAGES = DB_SYNC_STAGES_DEF
) (
  input  logic           clk,
  input  logic           rst,
  debounce_fsm_if.slave  bus
);

  localparam int              CNT_W    = $clog2(STABLE_CYC);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(STABLE_CYC - 1);

  logic            s;
  debounce_state_t state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic            tick_reg, tick_next;

  bit_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (bus.sw_raw),
    .q   (s)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ZERO;
      cnt_reg   <= '0;
      tick_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      tick_reg  <= tick_next;
    end
  end

  // A reversal of s inside a wait state drops back without touching the output;
  // the count is reloaded on the next entry, so a stale value is harmless.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    tick_next  = 1'b0;
    unique case (state_reg)
      ZERO: begin
        if (s) begin
          state_next = WAIT1;
          cnt_next   = CNT_LOAD;
        end
      end
      WAIT1: begin
        if (!s) begin
          state_next = ZERO;
        end else if (cnt_reg == '0) begin
          state_next = ONE;
          tick_next  = 1'b1;
        end else begin
          cnt_next = cnt_reg - CNT_W'(1);
        end
      end
      ONE: begin
        if (!s) begin
          state_next = WAIT0;
          cnt_next   = CNT_LOAD;
        end
      end
      WAIT0: begin
        if (s) begin
          state_next = ONE;
        end else if (cnt_reg == '0) begin
          state_next = ZERO;
          tick_next  = 1'b1;
        end else begin
          cnt_next = cnt_reg - CNT_W'(1);
        end
      end
      default: begin
        state_next = ZERO;
      end
    endcase
  end

  assign bus.db_level = is_high_state(state_reg);
  assign bus.db_tick  = tick_reg;

endmodule

// File: tb/tb_debounce_fsm.sv
// Directed bench for debounce_fsm with STABLE_CYC=4, SYNC_STAGES=2 and a downstream edge detector.
module tb_debounce_fsm;
  import debounce_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  debounce_fsm_if bus ();

  debounce_fsm #(.STABLE_CYC(4), .SYNC_STAGES(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Downstream rising-edge detector: one registered pulse per rise of db_level.
  logic ed_prev  = 1'b0;
  logic ed_pulse = 1'b0;
  int   ed_count = 0;
  always @(posedge clk) begin
    ed_pulse <= bus.db_level & ~ed_prev;
    ed_prev  <= bus.db_level;
    if (ed_pulse) ed_count <= ed_count + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive a held new value; edge 0 is the first sampling edge, level flips after edge 6.
  task automatic watch(input string tag, input logic new_val);
    bus.sw_raw = new_val;
    for (int i = 0; i < 8; i++) begin
      step();
      check($sformatf("%s_lvl_e%0d", tag, i), bus.db_level, (i >= 6) ? new_val : ~new_val);
      check($sformatf("%s_tick_e%0d", tag, i), bus.db_tick, (i == 6) ? 1'b1 : 1'b0);
    end
    $display("[TB] %s: drove %b, db_level now %b", tag, new_val, bus.db_level);
  endtask

  task automatic drive_quiet(input string tag, input logic val);
    bus.sw_raw = val;
    step();
    check({tag, "_lvl"}, bus.db_level, 1'b0);
    check({tag, "_tick"}, bus.db_tick, 1'b0);
  endtask

  int base;

  initial begin
    bus.sw_raw = 1'b0;
    rst = 1'b1;

    // Reset held while input toggles
    for (int i = 0; i < 6; i++) begin
      bus.sw_raw = i[0];
      step();
      check($sformatf("rst_lvl_%0d", i), bus.db_level, 1'b0);
      check($sformatf("rst_tick_%0d", i), bus.db_tick, 1'b0);
    end
    $display("[TB] reset hold with toggling input");
    bus.sw_raw = 1'b0;
    rst = 1'b0;
    repeat (3) step();

    watch("press", 1'b1);
    watch("release", 1'b0);
    repeat (2) step();

    // Bounce 1,1,0,1,1,0 then steady 1
    drive_quiet("bnc0", 1'b1);
    drive_quiet("bnc1", 1'b1);
    drive_quiet("bnc2", 1'b0);
    drive_quiet("bnc3", 1'b1);
    drive_quiet("bnc4", 1'b1);
    drive_quiet("bnc5", 1'b0);
    watch("bounce_settle", 1'b1);
    watch("release2", 1'b0);
    repeat (2) step();

    // Reset in WAIT1 after the count has reached 2
    bus.sw_raw = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("midw_lvl_e%0d", i), bus.db_level, 1'b0);
    end
    rst = 1'b1;
    #1;
    check("midrst_lvl", bus.db_level, 1'b0);
    step();
    step();
    check("midrst_lvl_held", bus.db_level, 1'b0);
    check("midrst_tick_held", bus.db_tick, 1'b0);
    rst = 1'b0;
    $display("[TB] reset asserted mid-wait and released with input high");
    watch("post_rst", 1'b1);
    watch("release3", 1'b0);
    repeat (4) step();

    // Chained edge detector: one press gives one pulse
    base = ed_count;
    watch("chain_press", 1'b1);
    repeat (4) step();
    check_int("chain_press_pulses", ed_count - base, 1);
    watch("chain_release", 1'b0);
    repeat (4) step();

    // Five-cycle bounce train gives no pulse
    base = ed_count;
    drive_quiet("train0", 1'b1);
    drive_quiet("train1", 1'b0);
    drive_quiet("train2", 1'b1);
    drive_quiet("train3", 1'b0);
    drive_quiet("train4", 1'b1);
    bus.sw_raw = 1'b0;
    repeat (10) step();
    check("train_lvl", bus.db_level, 1'b0);
    check_int("train_pulses", ed_count - base, 0);
    $display("[TB] bounce train into edge detector");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
